// File: rtl/ram_check_pkg.sv
// Shared definitions for the RAM init-check scheduler: state encoding,
// default sizing and the cleared value of the per-channel result maps.
package ram_check_pkg;

    localparam int DEF_N_CH    = 16;
    localparam int DEF_TMO_W   = 20;
    localparam int DEF_TMO_CYC = 500000;

    // Wide enough for the largest supported channel count; sliced by users.
    localparam logic [15:0] MAP_CLR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAUNCH,
        ST_WAIT,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/ram_check_wdog.sv
// Per-launch watchdog: cleared when a checker is launched, counts while the
// scheduler waits, and flags expiry on the last allowed cycle.
module ram_check_wdog #(
    parameter int TMO_W   = 20,
    parameter int TMO_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] count;

    // Saturates at all-ones so a stuck enable can never wrap into a false expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/ram_check_scheduler.sv
// Runs the per-RAM init checkers strictly one at a time, guarding each with a
// watchdog and collecting per-channel error and timeout bitmaps.
module ram_check_scheduler
    import ram_check_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int TMO_W   = DEF_TMO_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic            sys_clk,
    input  logic            glbl_rst,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [N_CH-1:0] err_map,
    output logic [N_CH-1:0] tmo_map,
    output logic [3:0]      cur_ch,
    output logic [N_CH-1:0] init_check_en,
    input  logic [N_CH-1:0] init_check_done,
    input  logic [N_CH-1:0] init_check_error
);

    localparam logic [3:0] LAST_CH = 4'(N_CH - 1);

    state_t          state;
    logic [3:0]      idx;
    logic [N_CH-1:0] mask_q;
    logic [N_CH-1:0] idx_bit;
    logic            expire;
    logic            ch_err;
    logic            ch_done;
    logic            ch_tmo;
    logic            ch_exit;

    // Only the channel under test is observed; stray pulses elsewhere drop out here.
    assign idx_bit = N_CH'(1) << idx;
    assign ch_err  = |(init_check_error & idx_bit);
    assign ch_done = |(init_check_done & idx_bit);
    assign ch_tmo  = expire & ~ch_err & ~ch_done;
    assign ch_exit = ch_err | ch_done | expire;
    assign cur_ch  = idx;

    ram_check_wdog #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk    (sys_clk),
        .rst    (glbl_rst),
        .clear  (state == ST_LAUNCH),
        .enable (state == ST_WAIT),
        .expire (expire)
    );

    always_ff @(posedge sys_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            mask_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_map       <= MAP_CLR[N_CH-1:0];
            tmo_map       <= MAP_CLR[N_CH-1:0];
            init_check_en <= '0;
        end else begin
            done          <= 1'b0;
            error         <= 1'b0;
            init_check_en <= '0;
            if ((state != ST_IDLE) && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            mask_q  <= ch_mask;
                            err_map <= MAP_CLR[N_CH-1:0];
                            tmo_map <= MAP_CLR[N_CH-1:0];
                            idx     <= '0;
                            busy    <= 1'b1;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (|(mask_q & idx_bit)) begin
                            state <= ST_LAUNCH;
                        end else if (idx == LAST_CH) begin
                            state <= ST_REPORT;
                            done  <= 1'b1;
                            error <= |(err_map | tmo_map);
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    ST_LAUNCH: begin
                        init_check_en <= idx_bit;
                        state         <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (ch_exit) begin
                            if (ch_err) err_map <= err_map | idx_bit;
                            if (ch_tmo) tmo_map <= tmo_map | idx_bit;
                            // The pulse goes out as REPORT is entered so it already reflects this channel.
                            if (idx == LAST_CH) begin
                                state <= ST_REPORT;
                                done  <= 1'b1;
                                error <= (|(err_map | tmo_map)) | ch_err | ch_tmo;
                            end else begin
                                idx   <= idx + 4'd1;
                                state <= ST_SCAN;
                            end
                        end
                    end
                    ST_REPORT: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_check_scheduler.sv
// Bench for ram_check_scheduler: emulated checkers plus a pass-level timeline
// model that predicts every cycle of busy/done/error/en and the final maps.
module tb_ram_check_scheduler;

    localparam int TMO      = 100;
    localparam int K_DONE   = 0;
    localparam int K_ERR    = 1;
    localparam int K_BOTH   = 2;
    localparam int K_SILENT = 3;

    logic        clk      = 1'b0;
    logic        glbl_rst = 1'b1;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic [15:0] ch_mask  = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] err_map;
    logic [15:0] tmo_map;
    logic [3:0]  cur_ch;
    logic [15:0] en;
    logic [15:0] resp_done  = '0;
    logic [15:0] resp_err   = '0;
    logic [15:0] stray_done = '0;
    logic [15:0] all_done;

    int kind [16];
    int dly  [16];
    int cnt  [16];
    int checks = 0;
    int errors = 0;
    int seen;

    assign all_done = resp_done | stray_done;

    always #5 clk = ~clk;

    ram_check_scheduler #(
        .N_CH    (16),
        .TMO_W   (20),
        .TMO_CYC (TMO)
    ) dut (
        .sys_clk          (clk),
        .glbl_rst         (glbl_rst),
        .start            (start),
        .abort            (abort),
        .ch_mask          (ch_mask),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_map          (err_map),
        .tmo_map          (tmo_map),
        .cur_ch           (cur_ch),
        .init_check_en    (en),
        .init_check_done  (all_done),
        .init_check_error (resp_err)
    );

    // Checker emulation: answer dly[k] cycles after the en pulse is seen.
    initial begin
        for (int k = 0; k < 16; k++) cnt[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_done = '0;
            resp_err  = '0;
            for (int k = 0; k < 16; k++) begin
                if (glbl_rst) begin
                    cnt[k] = 0;
                end else begin
                    if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            if (kind[k] == K_DONE || kind[k] == K_BOTH) resp_done[k] = 1'b1;
                            if (kind[k] == K_ERR  || kind[k] == K_BOTH) resp_err[k]  = 1'b1;
                        end
                    end
                    if (en[k] && kind[k] != K_SILENT) cnt[k] = dly[k];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_all(input int k_kind, input int d);
        for (int k = 0; k < 16; k++) begin
            kind[k] = k_kind;
            dly[k]  = d;
        end
    endtask

    // Predicts the pass from per-channel costs: skipped 1, answered 3+D, silent 2+TMO.
    task automatic run_pass(input string name, input logic [15:0] mask, input int abort_rel,
                            input int extra_rel, input int stray_rel, output int done_seen);
        int          en_exp [16];
        int          t, done_rel, last_busy, end_rel, lim, exit_rel;
        logic [15:0] exp_err, exp_tmo, exp_en;
        logic        exp_done, ch_valid;
        logic [3:0]  exp_ch;
        t       = 1;
        exp_err = '0;
        exp_tmo = '0;
        lim     = (abort_rel >= 0) ? abort_rel : 32'h3fff_ffff;
        for (int k = 0; k < 16; k++) begin
            en_exp[k] = -1;
            if (mask[k]) begin
                en_exp[k] = t + 2;
                if (kind[k] == K_SILENT) begin
                    exit_rel = t + 2 + TMO - 1;
                    t += 2 + TMO;
                end else begin
                    exit_rel = t + 2 + dly[k];
                    t += 3 + dly[k];
                end
                if (exit_rel < lim) begin
                    if (kind[k] == K_ERR || kind[k] == K_BOTH) exp_err[k] = 1'b1;
                    if (kind[k] == K_SILENT) exp_tmo[k] = 1'b1;
                end
                if (en_exp[k] > lim) en_exp[k] = -1;
            end else begin
                t += 1;
            end
        end
        done_rel  = t;
        last_busy = (abort_rel >= 0) ? abort_rel : done_rel;
        end_rel   = last_busy + 3;
        done_seen = -1;
        for (int rel = 0; rel <= end_rel; rel++) begin
            @(negedge clk);
            start      = (rel == 0) || (rel == extra_rel);
            ch_mask    = (rel == 0) ? mask : ~mask;
            abort      = (rel == abort_rel);
            stray_done = (rel == stray_rel) ? 16'h0020 : 16'h0000;
            exp_en   = '0;
            ch_valid = 1'b0;
            exp_ch   = '0;
            for (int k = 0; k < 16; k++) begin
                if (en_exp[k] == rel) begin
                    exp_en[k] = 1'b1;
                    ch_valid  = 1'b1;
                    exp_ch    = 4'(k);
                end
            end
            exp_done = (abort_rel < 0) && (rel == done_rel);
            check($sformatf("%s busy@%0d", name, rel), busy, (rel >= 1) && (rel <= last_busy));
            check($sformatf("%s done@%0d", name, rel), done, exp_done);
            check($sformatf("%s error@%0d", name, rel), error, exp_done && (|(exp_err | exp_tmo)));
            check($sformatf("%s en@%0d", name, rel), en, exp_en);
            if (ch_valid) check($sformatf("%s cur_ch@%0d", name, rel), cur_ch, exp_ch);
            if (rel == 1 && abort_rel != 0) begin
                check($sformatf("%s err_map cleared", name), err_map, 16'h0000);
                check($sformatf("%s tmo_map cleared", name), tmo_map, 16'h0000);
            end
            if (done === 1'b1) done_seen = rel;
        end
        start      = 1'b0;
        abort      = 1'b0;
        stray_done = '0;
        ch_mask    = '0;
        check($sformatf("%s err_map", name), err_map, exp_err);
        check($sformatf("%s tmo_map", name), tmo_map, exp_tmo);
        $display("pass %s: mask=%h done_at=%0d err_map=%h tmo_map=%h", name, mask, done_seen, err_map, tmo_map);
    endtask

    initial begin
        set_all(K_DONE, 10);
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done/error", {done, error}, 2'b00);
        check("reset maps", {err_map, tmo_map}, 32'h0);
        check("reset cur_ch/en", {cur_ch, en}, 20'h0);
        $display("reset: busy=%b done=%b en=%h", busy, done, en);
        glbl_rst = 1'b0;
        repeat (2) @(negedge clk);

        set_all(K_DONE, 10);
        run_pass("all16", 16'hFFFF, -1, 50, -1, seen);
        check("all16 done cycle", seen, 209);

        set_all(K_DONE, 4);
        dly[2]  = 6;
        kind[2] = K_BOTH;
        run_pass("err_ch2", 16'h0005, -1, -1, -1, seen);
        check("err_ch2 err_map literal", err_map, 16'h0004);
        check("err_ch2 done cycle", seen, 31);

        set_all(K_SILENT, 1);
        run_pass("tmo_ch0", 16'h0001, -1, -1, -1, seen);
        check("tmo_ch0 tmo_map literal", tmo_map, 16'h0001);
        check("tmo_ch0 done cycle", seen, 118);

        set_all(K_DONE, 20);
        dly[5] = 3;
        run_pass("stray_ch5", 16'h0028, -1, -1, 11, seen);
        check("stray_ch5 done cycle", seen, 44);

        set_all(K_DONE, 5);
        kind[6] = K_ERR;
        kind[7] = K_SILENT;
        run_pass("abort_ch7", 16'h00C0, 40, -1, -1, seen);
        check("abort_ch7 partial err_map", err_map, 16'h0040);
        check("abort_ch7 no done", seen, -1);

        set_all(K_DONE, 5);
        run_pass("restart_empty", 16'h0000, -1, -1, -1, seen);
        check("restart_empty done cycle", seen, 17);

        run_pass("start_abort_idle", 16'hFFFF, 0, -1, -1, seen);
        check("start_abort_idle no done", seen, -1);

        // Reset in the middle of a wait: everything returns to zero, nothing fires later.
        set_all(K_DONE, 10);
        kind[0] = K_ERR;
        @(negedge clk);
        start   = 1'b1;
        ch_mask = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("midwait busy", busy, 1'b1);
        check("midwait err_map", err_map, 16'h0001);
        glbl_rst = 1'b1;
        @(negedge clk);
        check("midwait reset busy/done/error", {busy, done, error}, 3'b000);
        check("midwait reset maps", {err_map, tmo_map}, 32'h0);
        check("midwait reset cur_ch/en", {cur_ch, en}, 20'h0);
        glbl_rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check($sformatf("post-reset quiet@%0d", i), {busy, done, error, en}, 19'h0);
        end
        $display("midwait reset: busy=%b err_map=%h", busy, err_map);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
